pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Game-rule stage downstream of the paddle/ball position logic in the pong top level.
//  Samples ball and right-paddle positions once per frame.
//  Detects paddle hits and misses, keeps a 2-digit BCD hit score and a lives counter.
//  Sequences IDLE/SERVE/PLAY/MISS/OVER and drives serve/freeze controls back to the ball stage.
// PARAMETERS
//  PADDLE_X_L    540  left edge (px) of right paddle face
//  PADDLE_HALF   20   paddle half-height (px)
//  BALL_HALF     5    ball half-size (px)
//  MISS_X        635  ball_x_pos >= this in PLAY => miss
//  LIVES_INIT    3    lives at game start (1..3)
//  SERVE_FRAMES  60   frames held in SERVE and in MISS before advancing
// PORTS
//  clk               in   1   pixel clock (divided clock)
//  reset_n           in   1   async active-low reset
//  frame_tick        in   1   1-clk pulse once per frame (start of vblank)
//  start_btn         in   1   raw start button, asynchronous to clk
//  ball_x_pos        in   10  ball centre x (px)
//  ball_y_pos        in   10  ball centre y (px)
//  right_paddle_pos  in   10  paddle centre y (px)
//  serve             out  1   1-clk pulse: ball stage re-centres and launches
//  freeze            out  1   ball stage holds position while high
//  hit_pulse         out  1   1-clk pulse per counted hit
//  score_bcd         out  8   {tens,units} BCD hit count, saturates at 8'h99
//  lives             out  2   remaining lives
//  game_over         out  1   high in OVER
//  state             out  3   IDLE=0 SERVE=1 PLAY=2 MISS=3 OVER=4
// BEHAVIOUR
//  Reset (async, any cycle, including mid-game) gives:
//   state=IDLE, score=0, lives=LIVES_INIT, serve=0, hit_pulse=0, freeze=1, game_over=0.
//   Frame counter, prev_x, hit_armed and synchronizer flops are also cleared.
//  start_btn: 2-flop synchronizer, then rising-edge detect -> start (1 clk); a held button counts once.
//  Position inputs are evaluated only on cycles with frame_tick=1; prev_x is latched on every frame_tick.
//  Geometry uses 11-bit unsigned sums; no subtraction, so there is no underflow near y=0:
//   y_hit = (ball_y+PADDLE_HALF+BALL_HALF >= pad_y) && (ball_y <= pad_y+PADDLE_HALF+BALL_HALF)
//   x_hit = (ball_x+BALL_HALF >= PADDLE_X_L) && (ball_x < MISS_X)
//   moving_right = ball_x > prev_x
//  hit_armed: set when ball_x < prev_x (moving left) or on serve; cleared on a counted hit.
//   Result: at most one hit per approach.
//  FSM transitions:
//   IDLE : start -> SERVE (score<=0, lives<=LIVES_INIT, frame cnt<=0).
//   SERVE: counts frame_ticks; at SERVE_FRAMES-th tick -> PLAY, serve=1 that cycle.
//   PLAY : on frame_tick, if x_hit&&y_hit&&moving_right&&hit_armed:
//           hit_pulse=1, score+=1 BCD (units 9->0 carries tens; 99 holds).
//          On frame_tick, if ball_x>=MISS_X: lives-=1 -> MISS.
//          Hit and miss in the same frame: the miss wins, no score.
//   MISS : hold SERVE_FRAMES ticks; then lives==0 -> OVER, else -> SERVE.
//   OVER : start -> SERVE with score cleared, lives reset.
//  start is ignored in SERVE/PLAY/MISS.
//  freeze = 1 in every state except PLAY; it is registered and changes on the same edge as state.
//  serve/hit_pulse are registered, exactly 1 clk wide.
//  Latency: frame_tick at cycle N -> state/score/lives/pulses updated at N+1.
//  lives never decrements below 0; score never wraps.
// TESTING
//  1 Reset mid-PLAY with score=12 -> next cycle: state=0, score=00, lives=3, freeze=1.
//  2 start held 100 clks in IDLE -> single SERVE entry; after 60 ticks, one serve pulse, state=2.
//  3 PLAY, pad=240, ball (545,262) moving right -> hit_pulse, score 01; same pos next frame -> no 2nd hit.
//  4 score=09 hit -> 10; score=99 hit -> stays 99, hit_pulse still 1.
//  5 ball_x=635 three times (each via SERVE) -> lives 2,1,0; after MISS hold -> OVER, game_over=1.
//  6 pad=10, ball_y=0 in x_hit window -> counted hit (no underflow); same frame ball_x=635 -> miss only.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game-rule controller: per-frame hit/miss detection, BCD score, lives
// and the IDLE/SERVE/PLAY/MISS/OVER sequencer driving the ball stage.
module pong_game_ctrl #(
  parameter int PADDLE_X_L   = 540,
  parameter int PADDLE_HALF  = 20,
  parameter int BALL_HALF    = 5,
  parameter int MISS_X       = 635,
  parameter int LIVES_INIT   = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [9:0] ball_x_pos,
  input  logic [9:0] ball_y_pos,
  input  logic [9:0] right_paddle_pos,
  output logic       serve,
  output logic       freeze,
  output logic       hit_pulse,
  output logic [7:0] score_bcd,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [10:0]      REACH     = 11'(PADDLE_HALF + BALL_HALF);
  localparam logic [10:0]      BALL_H11  = 11'(BALL_HALF);
  localparam logic [10:0]      PAD_X11   = 11'(PADDLE_X_L);
  localparam logic [10:0]      MISS_X11  = 11'(MISS_X);
  localparam logic [1:0]       LIVES_RST = 2'(LIVES_INIT);

  state_t           state_q, state_d;
  logic [7:0]       score_q, score_d;
  logic [1:0]       lives_q, lives_d;
  logic             serve_q, serve_d;
  logic             hit_q, hit_d;
  logic             freeze_q, freeze_d;
  logic             over_q, over_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       prev_x_q, prev_x_d;
  logic             armed_q, armed_d;
  logic [2:0]       sync_q, sync_d;

  logic [10:0] bx, by, py;
  logic        start, x_hit, y_hit, moving_right, missed;
  logic [7:0]  score_inc;

  // All geometry is done with 11-bit additions only, so nothing underflows near y=0.
  always_comb begin
    bx           = {1'b0, ball_x_pos};
    by           = {1'b0, ball_y_pos};
    py           = {1'b0, right_paddle_pos};
    start        = sync_q[1] & ~sync_q[2];
    y_hit        = (by + REACH >= py) && (by <= py + REACH);
    x_hit        = (bx + BALL_H11 >= PAD_X11) && (bx < MISS_X11);
    moving_right = ball_x_pos > prev_x_q;
    missed       = bx >= MISS_X11;
    if (score_q == 8'h99)
      score_inc = score_q;
    else if (score_q[3:0] == 4'd9)
      score_inc = {score_q[7:4] + 4'd1, 4'd0};
    else
      score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
  end

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    lives_d  = lives_q;
    cnt_d    = cnt_q;
    serve_d  = 1'b0;
    hit_d    = 1'b0;
    sync_d   = {sync_q[1:0], start_btn};
    prev_x_d = frame_tick ? ball_x_pos : prev_x_q;
    armed_d  = armed_q | (frame_tick && (ball_x_pos < prev_x_q));

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_SERVE;
          score_d = 8'h00;
          lives_d = LIVES_RST;
          cnt_d   = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_PLAY;
            serve_d = 1'b1;
            armed_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // A miss outranks a hit detected in the same frame.
      ST_PLAY: begin
        if (frame_tick) begin
          if (missed) begin
            lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            state_d = ST_MISS;
            cnt_d   = '0;
          end else if (x_hit && y_hit && moving_right && armed_q) begin
            hit_d   = 1'b1;
            armed_d = 1'b0;
            score_d = score_inc;
          end
        end
      end
      ST_MISS: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = (lives_q == 2'd0) ? ST_OVER : ST_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    freeze_d = (state_d != ST_PLAY);
    over_d   = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      score_q  <= 8'h00;
      lives_q  <= LIVES_RST;
      serve_q  <= 1'b0;
      hit_q    <= 1'b0;
      freeze_q <= 1'b1;
      over_q   <= 1'b0;
      cnt_q    <= '0;
      prev_x_q <= '0;
      armed_q  <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      serve_q  <= serve_d;
      hit_q    <= hit_d;
      freeze_q <= freeze_d;
      over_q   <= over_d;
      cnt_q    <= cnt_d;
      prev_x_q <= prev_x_d;
      armed_q  <= armed_d;
      sync_q   <= sync_d;
    end
  end

  assign state     = state_q;
  assign score_bcd = score_q;
  assign lives     = lives_q;
  assign serve     = serve_q;
  assign hit_pulse = hit_q;
  assign freeze    = freeze_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares whenever the DUT changes state or pulses.
module tb_pong_game_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_MISS  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  typedef struct packed {
    logic [2:0]  st;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic        hit;
    logic        srv;
    logic        frz;
    logic        over;
    logic [15:0] tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic [9:0] ball_x = '0;
  logic [9:0] ball_y = '0;
  logic [9:0] pad_y = '0;
  logic       serve, freeze, hit_pulse, game_over;
  logic [7:0] score_bcd;
  logic [1:0] lives;
  logic [2:0] state;

  exp_t exp_q[$];
  int   tick_count = 0;
  int   errors = 0;
  int   checks = 0;
  int   m_hits = 0;
  int   m_lives = 3;

  pong_game_ctrl dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start_btn(start_btn),
    .ball_x_pos(ball_x), .ball_y_pos(ball_y), .right_paddle_pos(pad_y),
    .serve(serve), .freeze(freeze), .hit_pulse(hit_pulse), .score_bcd(score_bcd),
    .lives(lives), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    int v;
    v = (n > 99) ? 99 : n;
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic push_exp(input logic [2:0] st, input bit hit, input bit srv);
    exp_t e;
    e.st    = st;
    e.score = to_bcd(m_hits);
    e.lives = 2'(m_lives);
    e.hit   = hit;
    e.srv   = srv;
    e.frz   = (st != S_PLAY);
    e.over  = (st == S_OVER);
    e.tick  = 16'(tick_count);
    exp_q.push_back(e);
  endtask

  // One frame: positions presented with frame_tick for a single clock.
  task automatic applyStimulus(input int bx, input int by, input int pad,
                               input bit expect_evt, input logic [2:0] st,
                               input bit hit, input bit srv);
    @(posedge clk); #1;
    ball_x     = 10'(bx);
    ball_y     = 10'(by);
    pad_y      = 10'(pad);
    tick_count = tick_count + 1;
    if (expect_evt) push_exp(st, hit, srv);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic checkOutput(input exp_t act);
    exp_t e;
    checks = checks + 1;
    if (exp_q.size() == 0) begin
      errors = errors + 1;
      $display("[TB] FAIL unexpected_event: got st=%0d score=%h lives=%0d hit=%0b srv=%0b frz=%0b over=%0b tick=%0d, none expected",
               act.st, act.score, act.lives, act.hit, act.srv, act.frz, act.over, act.tick);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors = errors + 1;
        $display("[TB] FAIL event: got st=%0d score=%h lives=%0d hit=%0b srv=%0b frz=%0b over=%0b tick=%0d, expected st=%0d score=%h lives=%0d hit=%0b srv=%0b frz=%0b over=%0b tick=%0d",
                 act.st, act.score, act.lives, act.hit, act.srv, act.frz, act.over, act.tick,
                 e.st, e.score, e.lives, e.hit, e.srv, e.frz, e.over, e.tick);
      end
    end
  endtask

  task automatic press_start(input int hold, input bit expect_evt);
    @(posedge clk); #1;
    if (expect_evt) push_exp(S_SERVE, 1'b0, 1'b0);
    start_btn = 1'b1;
    repeat (hold) @(posedge clk);
    #1 start_btn = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic serve_seq();
    for (int i = 1; i <= 60; i++)
      applyStimulus(320, 240, 240, i == 60, S_PLAY, 1'b0, i == 60);
  endtask

  task automatic miss_hold(input logic [2:0] next_st);
    for (int i = 1; i <= 60; i++)
      applyStimulus(320, 240, 240, i == 60, next_st, 1'b0, 1'b0);
  endtask

  // Left-moving frame to re-arm, then an approach that may or may not score.
  task automatic attempt(input int bx, input int by, input int pad, input bit is_hit);
    applyStimulus(300, 240, 240, 1'b0, S_PLAY, 1'b0, 1'b0);
    if (is_hit) m_hits = m_hits + 1;
    applyStimulus(bx, by, pad, is_hit, S_PLAY, 1'b1, 1'b0);
  endtask

  task automatic miss_frame();
    applyStimulus(300, 240, 240, 1'b0, S_PLAY, 1'b0, 1'b0);
    m_lives = m_lives - 1;
    applyStimulus(635, 0, 10, 1'b1, S_MISS, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    logic [2:0] last_state;
    exp_t act;
    last_state = 3'd7;
    forever begin
      @(negedge clk);
      if (state != last_state || hit_pulse || serve) begin
        act.st    = state;
        act.score = score_bcd;
        act.lives = lives;
        act.hit   = hit_pulse;
        act.srv   = serve;
        act.frz   = freeze;
        act.over  = game_over;
        act.tick  = 16'(tick_count);
        checkOutput(act);
      end
      last_state = state;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    push_exp(S_IDLE, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Game 1: held start counts once, then geometry boundaries.
    press_start(100, 1'b1);
    serve_seq();
    m_hits = 1;
    applyStimulus(545, 262, 240, 1'b1, S_PLAY, 1'b1, 1'b0);
    applyStimulus(545, 262, 240, 1'b0, S_PLAY, 1'b0, 1'b0);
    applyStimulus(300, 240, 240, 1'b0, S_PLAY, 1'b0, 1'b0);
    applyStimulus(600, 100, 240, 1'b0, S_PLAY, 1'b0, 1'b0);
    applyStimulus(545, 262, 240, 1'b0, S_PLAY, 1'b0, 1'b0);
    attempt(534, 250, 240, 1'b0);
    attempt(535, 250, 240, 1'b1);
    attempt(545, 214, 240, 1'b0);
    attempt(545, 215, 240, 1'b1);
    attempt(545, 266, 240, 1'b0);
    attempt(545, 265, 240, 1'b1);
    attempt(545, 0, 10, 1'b1);
    attempt(634, 240, 240, 1'b1);
    for (int i = 0; i < 6; i++) attempt(545, 262, 240, 1'b1);
    press_start(5, 1'b0);

    // Asynchronous reset in the middle of play with score 12.
    @(posedge clk); #1;
    m_hits  = 0;
    m_lives = 3;
    push_exp(S_IDLE, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Game 2: score saturation, then three misses into OVER.
    press_start(5, 1'b1);
    serve_seq();
    for (int i = 0; i < 100; i++) attempt(545, 262, 240, 1'b1);
    miss_frame();
    press_start(5, 1'b0);
    miss_hold(S_SERVE);
    serve_seq();
    miss_frame();
    miss_hold(S_SERVE);
    serve_seq();
    miss_frame();
    miss_hold(S_OVER);

    m_hits  = 0;
    m_lives = 3;
    press_start(5, 1'b1);
    repeat (5) @(posedge clk);

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("[TB] FAIL missing_events: got %0d events still pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
